// File: rtl/ram_port_a_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module      : ram_port_a_arbiter_if
// Description : Bundle of the selection-requester, CPU-requester and RAM
//               port-A signals seen by ram_port_a_arbiter.
//               slave  : arbiter view (drives grants, RAM address/data/wren)
//               master : environment view (requesters and the RAM itself)
//               Optional macro ARB_CPU_STALL_CNT_EN adds cpu_stall_cnt.
// Revision    : 1.0 - initial release
// ============================================================================
interface ram_port_a_arbiter_if #(
  parameter int ADDR_W = 19
);
  // tie-break priority: 0 = selection wins, 1 = CPU wins
  logic              mode;
  // selection word writer
  logic              sel_req;
  logic [ADDR_W-1:0] sel_addr;
  logic [31:0]       sel_word;
  logic              sel_busy;
  logic              sel_done;
  // CPU byte port
  logic              cpu_req;
  logic              cpu_we;
  logic [ADDR_W-1:0] cpu_addr;
  logic [7:0]        cpu_wdata;
  logic              cpu_gnt;
  logic              cpu_rvalid;
  logic [7:0]        cpu_rdata;
  // RAM port A
  logic [ADDR_W-1:0] ram_address_a;
  logic [7:0]        ram_data_a;
  logic              ram_wren_a;
  logic [7:0]        ram_q_a;
`ifdef ARB_CPU_STALL_CNT_EN
  logic [15:0]       cpu_stall_cnt;
`endif

  modport slave (
    input  mode, sel_req, sel_addr, sel_word,
           cpu_req, cpu_we, cpu_addr, cpu_wdata, ram_q_a,
    output sel_busy, sel_done, cpu_gnt, cpu_rvalid, cpu_rdata,
           ram_address_a, ram_data_a, ram_wren_a
`ifdef ARB_CPU_STALL_CNT_EN
    , output cpu_stall_cnt
`endif
  );

  modport master (
    output mode, sel_req, sel_addr, sel_word,
           cpu_req, cpu_we, cpu_addr, cpu_wdata, ram_q_a,
    input  sel_busy, sel_done, cpu_gnt, cpu_rvalid, cpu_rdata,
           ram_address_a, ram_data_a, ram_wren_a
`ifdef ARB_CPU_STALL_CNT_EN
    , input cpu_stall_cnt
`endif
  );
endinterface
`default_nettype wire

// File: rtl/ram_port_a_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : ram_port_a_arbiter
// Description : Shares port A of the dual-port image RAM between the
//               selection-word writer (32-bit word -> four byte writes) and
//               the CPU byte port (single-byte reads/writes).
// Ports       : clk      - system clock, rising edge
//               reset_n  - asynchronous active-low reset, release synchronised
//               bus      - ram_port_a_arbiter_if.slave: requester handshakes,
//                          registered RAM port-A drive and read-data return
// Parameters  : ADDR_W   - RAM byte-address width
//               RD_LAT   - cycles from registered address to valid ram_q_a
// Macro       : ARB_CPU_STALL_CNT_EN - adds saturating cpu_stall_cnt[15:0]
// Revision    : 1.0 - initial release
// ============================================================================
module ram_port_a_arbiter #(
  parameter int ADDR_W = 19,
  parameter int RD_LAT = 2
) (
  input wire logic            clk,
  input wire logic            reset_n,
  ram_port_a_arbiter_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    CPU_ACC  = 2'd1,
    SEL_WR   = 2'd2,
    SEL_DONE = 2'd3
  } state_t;

  state_t            state_q, state_d;
  logic              arm_q, arm_d;
  logic [1:0]        bc_q, bc_d;
  logic [ADDR_W-1:0] base_q, base_d;
  logic [31:0]       word_q, word_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [7:0]        data_q, data_d;
  logic              wren_q, wren_d;
  logic              gnt_q, gnt_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic [RD_LAT-1:0] rd_pipe_q, rd_pipe_d;
`ifdef ARB_CPU_STALL_CNT_EN
  logic [15:0]       stall_q, stall_d;
`endif

  logic              take_sel;
  logic              take_cpu;
  logic [1:0]        bc_nxt;

  always_comb begin
    state_d   = state_q;
    arm_d     = 1'b1;
    bc_d      = bc_q;
    base_d    = base_q;
    word_d    = word_q;
    addr_d    = addr_q;
    data_d    = data_q;
    wren_d    = 1'b0;
    gnt_d     = 1'b0;
    busy_d    = busy_q;
    done_d    = 1'b0;
    take_sel  = 1'b0;
    take_cpu  = 1'b0;
    bc_nxt    = bc_q + 2'd1;
    rd_pipe_d = '0;

    case (state_q)
      IDLE: begin
        // arm_q holds arbitration off for one edge after reset release
        if (arm_q) begin
          take_sel = bus.sel_req & (~bus.cpu_req | ~bus.mode);
          take_cpu = bus.cpu_req & ~take_sel;
        end
        if (take_sel) begin
          base_d  = bus.sel_addr;
          word_d  = bus.sel_word;
          bc_d    = 2'd0;
          addr_d  = bus.sel_addr;
          data_d  = bus.sel_word[7:0];
          wren_d  = 1'b1;
          busy_d  = 1'b1;
          state_d = SEL_WR;
        end else if (take_cpu) begin
          addr_d  = bus.cpu_addr;
          data_d  = bus.cpu_wdata;
          wren_d  = bus.cpu_we;
          gnt_d   = 1'b1;
          state_d = CPU_ACC;
        end
      end
      CPU_ACC: begin
        state_d = IDLE;
      end
      SEL_WR: begin
        if (bc_q == 2'd3) begin
          done_d  = 1'b1;
          state_d = SEL_DONE;
        end else begin
          // address wraps naturally at 2^ADDR_W
          bc_d   = bc_nxt;
          addr_d = base_q + {{(ADDR_W-2){1'b0}}, bc_nxt};
          data_d = word_q[{bc_nxt, 3'b000} +: 8];
          wren_d = 1'b1;
        end
      end
      SEL_DONE: begin
        busy_d  = 1'b0;
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    // A read is on the RAM bus during CPU_ACC with wren low; the bit then
    // travels RD_LAT stages so rvalid lines up with ram_q_a.
    rd_pipe_d[0] = (state_q == CPU_ACC) && !wren_q;
    for (int i = 1; i < RD_LAT; i++) begin
      rd_pipe_d[i] = rd_pipe_q[i-1];
    end

`ifdef ARB_CPU_STALL_CNT_EN
    stall_d = stall_q;
    if (bus.cpu_req && !gnt_q && (stall_q != 16'hFFFF)) begin
      stall_d = stall_q + 16'd1;
    end
`endif
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= IDLE;
      arm_q     <= 1'b0;
      bc_q      <= 2'd0;
      base_q    <= '0;
      word_q    <= '0;
      addr_q    <= '0;
      data_q    <= '0;
      wren_q    <= 1'b0;
      gnt_q     <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      rd_pipe_q <= '0;
`ifdef ARB_CPU_STALL_CNT_EN
      stall_q   <= '0;
`endif
    end else begin
      state_q   <= state_d;
      arm_q     <= arm_d;
      bc_q      <= bc_d;
      base_q    <= base_d;
      word_q    <= word_d;
      addr_q    <= addr_d;
      data_q    <= data_d;
      wren_q    <= wren_d;
      gnt_q     <= gnt_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      rd_pipe_q <= rd_pipe_d;
`ifdef ARB_CPU_STALL_CNT_EN
      stall_q   <= stall_d;
`endif
    end
  end

  assign bus.ram_address_a = addr_q;
  assign bus.ram_data_a    = data_q;
  assign bus.ram_wren_a    = wren_q;
  assign bus.cpu_gnt       = gnt_q;
  assign bus.sel_busy      = busy_q;
  assign bus.sel_done      = done_q;
  assign bus.cpu_rvalid    = rd_pipe_q[RD_LAT-1];
  // RAM output is passed through only while qualified so it reads 0 otherwise
  assign bus.cpu_rdata     = rd_pipe_q[RD_LAT-1] ? bus.ram_q_a : 8'h00;
`ifdef ARB_CPU_STALL_CNT_EN
  assign bus.cpu_stall_cnt = stall_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_ram_port_a_arbiter.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module      : tb_ram_port_a_arbiter
// Description : Directed stimulus for ram_port_a_arbiter with a queue-based
//               scoreboard; includes a latency-2 RAM model on port A.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_ram_port_a_arbiter;
  localparam int ADDR_W = 19;
  localparam int RD_LAT = 2;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  ram_port_a_arbiter_if #(.ADDR_W(ADDR_W)) bus();

  ram_port_a_arbiter #(.ADDR_W(ADDR_W), .RD_LAT(RD_LAT)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  // RAM model: registered address, registered output -> 2-cycle read latency
  logic [7:0]        ram_mem [0:(1<<ADDR_W)-1];
  logic [ADDR_W-1:0] ram_a1;
  logic [7:0]        ram_q;
  always @(posedge clk) begin
    if (bus.ram_wren_a) ram_mem[bus.ram_address_a] <= bus.ram_data_a;
    ram_a1 <= bus.ram_address_a;
    ram_q  <= ram_mem[ram_a1];
  end
  assign bus.ram_q_a = ram_q;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct packed {
    int                cyc;
    logic [ADDR_W-1:0] addr;
    logic [7:0]        data;
  } wr_t;
  typedef struct packed {
    int        cyc;
    logic [7:0] data;
  } rv_t;

  wr_t wr_q[$];
  rv_t rv_q[$];
  int  gnt_q[$];
  int  done_q[$];

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string name, input bit ok, input string got, input string exp);
    n_tests++;
    if (!ok) begin
      n_fail++;
      $display("FAIL %s: got %s, expected %s (t=%0t)", name, got, exp, $time);
    end
  endtask

  task automatic check_val(input string name, input logic [63:0] got, input logic [63:0] exp);
    check(name, got === exp, $sformatf("%0h", got), $sformatf("%0h", exp));
  endtask

  function automatic void push_wr(input int c, input logic [ADDR_W-1:0] a, input logic [7:0] d);
    wr_t e;
    e.cyc = c; e.addr = a; e.data = d;
    wr_q.push_back(e);
  endfunction

  function automatic void push_rv(input int c, input logic [7:0] d);
    rv_t e;
    e.cyc = c; e.data = d;
    rv_q.push_back(e);
  endfunction

  // four little-endian byte writes starting in cycle e, sel_done in e+4
  function automatic void push_burst(input int e, input logic [ADDR_W-1:0] a, input logic [31:0] w);
    for (int i = 0; i < 4; i++) push_wr(e + i, a + ADDR_W'(i), w[8*i +: 8]);
    done_q.push_back(e + 4);
  endfunction

  // Monitor: pops the expected event whenever the DUT presents a strobe
  always @(negedge clk) begin
    if (bus.ram_wren_a) begin
      if (wr_q.size() == 0) begin
        check("ram_write", 1'b0, $sformatf("cyc=%0d addr=%h data=%h", cyc, bus.ram_address_a, bus.ram_data_a), "no write");
      end else begin
        wr_t e;
        e = wr_q.pop_front();
        check("ram_write", (e.cyc == cyc) && (e.addr === bus.ram_address_a) && (e.data === bus.ram_data_a),
              $sformatf("cyc=%0d addr=%h data=%h", cyc, bus.ram_address_a, bus.ram_data_a),
              $sformatf("cyc=%0d addr=%h data=%h", e.cyc, e.addr, e.data));
      end
    end
    if (bus.cpu_gnt) begin
      if (gnt_q.size() == 0) begin
        check("cpu_gnt", 1'b0, $sformatf("cyc=%0d", cyc), "no grant");
      end else begin
        int g;
        g = gnt_q.pop_front();
        check("cpu_gnt", g == cyc, $sformatf("cyc=%0d", cyc), $sformatf("cyc=%0d", g));
      end
    end
    if (bus.cpu_rvalid) begin
      if (rv_q.size() == 0) begin
        check("cpu_rvalid", 1'b0, $sformatf("cyc=%0d data=%h", cyc, bus.cpu_rdata), "no read data");
      end else begin
        rv_t e;
        e = rv_q.pop_front();
        check("cpu_rvalid", (e.cyc == cyc) && (e.data === bus.cpu_rdata),
              $sformatf("cyc=%0d data=%h", cyc, bus.cpu_rdata),
              $sformatf("cyc=%0d data=%h", e.cyc, e.data));
      end
    end
    if (bus.sel_done) begin
      if (done_q.size() == 0) begin
        check("sel_done", 1'b0, $sformatf("cyc=%0d", cyc), "no sel_done");
      end else begin
        int d;
        d = done_q.pop_front();
        check("sel_done", d == cyc, $sformatf("cyc=%0d", cyc), $sformatf("cyc=%0d", d));
      end
    end
  end

  // Holds cpu_req until the grant, then drops it after the grant cycle.
  task automatic cpu_access(input logic we, input logic [ADDR_W-1:0] a, input logic [7:0] d);
    int n;
    n = 0;
    bus.cpu_req = 1'b1; bus.cpu_we = we; bus.cpu_addr = a; bus.cpu_wdata = d;
    while (!bus.cpu_gnt && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    if (n >= 50) check("cpu_gnt_timeout", 1'b0, "no grant in 50 cycles", "grant");
    @(posedge clk); #1;
    bus.cpu_req = 1'b0;
  endtask

  // One-cycle sel_req pulse; returns in the IDLE cycle after sel_done.
  task automatic sel_burst(input logic [ADDR_W-1:0] a, input logic [31:0] w);
    bus.sel_req = 1'b1; bus.sel_addr = a; bus.sel_word = w;
    @(posedge clk); #1;
    bus.sel_req = 1'b0;
    repeat (5) begin @(posedge clk); #1; end
  endtask

  task automatic check_reset_outputs(input string tag);
    check_val({tag, "_ram_address_a"}, 64'(bus.ram_address_a), 64'h0);
    check_val({tag, "_ram_data_a"},    64'(bus.ram_data_a),    64'h0);
    check_val({tag, "_ram_wren_a"},    64'(bus.ram_wren_a),    64'h0);
    check_val({tag, "_cpu_gnt"},       64'(bus.cpu_gnt),       64'h0);
    check_val({tag, "_cpu_rvalid"},    64'(bus.cpu_rvalid),    64'h0);
    check_val({tag, "_cpu_rdata"},     64'(bus.cpu_rdata),     64'h0);
    check_val({tag, "_sel_busy"},      64'(bus.sel_busy),      64'h0);
    check_val({tag, "_sel_done"},      64'(bus.sel_done),      64'h0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected $finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int c;
`ifdef ARB_CPU_STALL_CNT_EN
    int s0;
`endif
    bus.mode = 1'b0; bus.sel_req = 1'b0; bus.sel_addr = '0; bus.sel_word = '0;
    bus.cpu_req = 1'b0; bus.cpu_we = 1'b0; bus.cpu_addr = '0; bus.cpu_wdata = '0;

    // Reset state
    repeat (3) begin @(posedge clk); #1; end
    check_reset_outputs("reset");

    // Request waiting across reset release: first arbitration on the second edge
    bus.sel_req = 1'b1; bus.sel_addr = 19'h30E4D; bus.sel_word = 32'h0001_2C64;
    c = cyc;
    reset_n = 1'b1;
    push_wr(c + 2, 19'h30E4D, 8'h64);
    push_wr(c + 3, 19'h30E4E, 8'h2C);
    push_wr(c + 4, 19'h30E4F, 8'h01);
    push_wr(c + 5, 19'h30E50, 8'h00);
    done_q.push_back(c + 6);
    repeat (2) begin @(posedge clk); #1; end
    check_val("sel_busy_in_burst", 64'(bus.sel_busy), 64'h1);
    bus.sel_req = 1'b0;
    repeat (5) begin @(posedge clk); #1; end
    check_val("sel_busy_after_burst", 64'(bus.sel_busy), 64'h0);

    // CPU write then read back
    c = cyc;
    gnt_q.push_back(c + 1);
    push_wr(c + 1, 19'h00010, 8'hA5);
    cpu_access(1'b1, 19'h00010, 8'hA5);
    c = cyc;
    gnt_q.push_back(c + 1);
    push_rv(c + 1 + RD_LAT, 8'hA5);
    cpu_access(1'b0, 19'h00010, 8'h00);
    repeat (3) begin @(posedge clk); #1; end

    // Tie with mode=0: selection first, CPU read granted at +7
    bus.mode = 1'b0;
    c = cyc;
    push_burst(c + 1, 19'h01000, 32'hDEAD_BEEF);
    gnt_q.push_back(c + 7);
    push_rv(c + 7 + RD_LAT, 8'hA5);
    bus.sel_req = 1'b1; bus.sel_addr = 19'h01000; bus.sel_word = 32'hDEAD_BEEF;
    fork
      begin @(posedge clk); #1; bus.sel_req = 1'b0; end
      cpu_access(1'b0, 19'h00010, 8'h00);
    join
    repeat (3) begin @(posedge clk); #1; end

    // Tie with mode=1: CPU write granted at +1, burst starts at +3
    bus.mode = 1'b1;
    c = cyc;
    gnt_q.push_back(c + 1);
    push_wr(c + 1, 19'h00020, 8'h3C);
    push_burst(c + 3, 19'h02000, 32'h1122_3344);
    bus.sel_req = 1'b1; bus.sel_addr = 19'h02000; bus.sel_word = 32'h1122_3344;
    fork
      begin repeat (3) @(posedge clk); #1; bus.sel_req = 1'b0; end
      cpu_access(1'b1, 19'h00020, 8'h3C);
    join
    repeat (8) begin @(posedge clk); #1; end
    bus.mode = 1'b0;

    // Read back bytes written above through the RAM model
    c = cyc;
    gnt_q.push_back(c + 1);
    push_rv(c + 1 + RD_LAT, 8'h3C);
    cpu_access(1'b0, 19'h00020, 8'h00);
    c = cyc;
    gnt_q.push_back(c + 1);
    push_rv(c + 1 + RD_LAT, 8'hAD);
    cpu_access(1'b0, 19'h01002, 8'h00);
    repeat (3) begin @(posedge clk); #1; end

    // Address wrap at the top of the RAM
    c = cyc;
    push_wr(c + 1, 19'h7FFFE, 8'hD4);
    push_wr(c + 2, 19'h7FFFF, 8'hC3);
    push_wr(c + 3, 19'h00000, 8'hB2);
    push_wr(c + 4, 19'h00001, 8'hA1);
    done_q.push_back(c + 5);
    sel_burst(19'h7FFFE, 32'hA1B2_C3D4);

    // Reset during the second byte write: burst abandoned
    c = cyc;
    push_wr(c + 1, 19'h04000, 8'h88);
    push_wr(c + 2, 19'h04001, 8'h77);
    bus.sel_req = 1'b1; bus.sel_addr = 19'h04000; bus.sel_word = 32'h5566_7788;
    @(posedge clk); #1;
    bus.sel_req = 1'b0;
    @(posedge clk);
    @(negedge clk); #1;
    reset_n = 1'b0;
    #1;
    check_reset_outputs("midburst_reset");
    repeat (3) begin @(posedge clk); #1; end
    check_reset_outputs("held_reset");
    reset_n = 1'b1;
    repeat (3) begin @(posedge clk); #1; end
    c = cyc;
    push_burst(c + 1, 19'h05000, 32'hCAFE_F00D);
    sel_burst(19'h05000, 32'hCAFE_F00D);

`ifdef ARB_CPU_STALL_CNT_EN
    // CPU held off by one burst accumulates 6 stall cycles
    s0 = int'(bus.cpu_stall_cnt);
    c = cyc;
    push_burst(c + 1, 19'h06000, 32'h0102_0304);
    gnt_q.push_back(c + 7);
    push_wr(c + 7, 19'h00030, 8'h5A);
    bus.sel_req = 1'b1; bus.sel_addr = 19'h06000; bus.sel_word = 32'h0102_0304;
    @(posedge clk); #1;
    bus.sel_req = 1'b0;
    cpu_access(1'b1, 19'h00030, 8'h5A);
    check_val("cpu_stall_cnt_delta", 64'(int'(bus.cpu_stall_cnt) - s0), 64'd6);
`endif

    repeat (10) begin @(posedge clk); #1; end
    check_val("pending_writes",  64'(wr_q.size()),   64'h0);
    check_val("pending_grants",  64'(gnt_q.size()),  64'h0);
    check_val("pending_rvalids", 64'(rv_q.size()),   64'h0);
    check_val("pending_dones",   64'(done_q.size()), 64'h0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/ram_port_a_arbiter.md
# ram_port_a_arbiter

Owns port A of the dual-port image RAM and shares it between two requesters: the selection-word writer and the pipelined CPU byte port. The selection requester hands over one 32-bit little-endian word plus a base address; the arbiter serialises it into four byte writes. The CPU requester issues single-byte reads and writes. `mode` sets which requester wins a tie. Port B (VGA scan-out) is untouched.

## Interface
- `ADDR_W`, 19, RAM byte-address width
- `RD_LAT`, 2, cycles from a registered address on `ram_address_a` to valid `ram_q_a`
- `clk` in 1 system clock; all logic on rising edge
- `reset_n` in 1 asynchronous, active-low reset
- `mode` in 1 tie-break priority: 0 = selection wins, 1 = CPU wins; sampled only in IDLE
- `sel_req` in 1 selection burst request
- `sel_addr` in ADDR_W base byte address
- `sel_word` in 32 word to write, little-endian
- `sel_busy` out 1 high from burst capture until `sel_done`
- `sel_done` out 1 one-cycle pulse when the burst completes
- `cpu_req` in 1 CPU access request, held until `cpu_gnt`
- `cpu_we` in 1 1 = write, 0 = read
- `cpu_addr` in ADDR_W CPU byte address
- `cpu_wdata` in 8 CPU write byte
- `cpu_gnt` out 1 one-cycle pulse; access issued to RAM this cycle
- `cpu_rvalid` out 1 one-cycle pulse when read data is valid
- `cpu_rdata` out 8 read byte, qualified by `cpu_rvalid`
- `ram_address_a` out ADDR_W registered RAM port-A address
- `ram_data_a` out 8 registered RAM port-A write data
- `ram_wren_a` out 1 registered RAM port-A write enable
- `ram_q_a` in 8 RAM port-A read data

## Operation
- States: IDLE, CPU_ACC, SEL_WR, SEL_DONE.
- **IDLE**
  - If only `sel_req` is high: capture `sel_addr` and `sel_word`, clear byte counter `bc`, go to SEL_WR.
  - If only `cpu_req` is high: capture the CPU access, go to CPU_ACC.
  - If both are high: `mode`=0 goes to SEL_WR, `mode`=1 goes to CPU_ACC. The loser keeps its request pending.
- **CPU_ACC** (1 cycle)
  - `ram_address_a`=`cpu_addr`, `ram_wren_a`=`cpu_we`, `ram_data_a`=`cpu_wdata`, `cpu_gnt`=1.
  - Next state IDLE.
  - For a read: `cpu_rvalid`=1 and `cpu_rdata`=`ram_q_a` exactly RD_LAT cycles after the CPU_ACC cycle.
  - A new access may start while an earlier read is still in flight. A tracking shift register of depth RD_LAT keeps each rvalid aligned.
- **SEL_WR** (4 cycles, `bc`=0..3)
  - `ram_address_a`=(base+`bc`) mod 2^ADDR_W.
  - `ram_data_a`=`sel_word[8*bc+7:8*bc]`, `ram_wren_a`=1.
  - After `bc`=3, go to SEL_DONE.
  - The burst is never pre-empted. `cpu_req` waits.
- **SEL_DONE** (1 cycle): `sel_done`=1, `ram_wren_a`=0, next state IDLE.
- `sel_busy`=1 in SEL_WR and SEL_DONE.
- The selection requester must drop `sel_req` by the `sel_done` cycle. If `sel_req` is still high in the following IDLE, that is a new burst.
- `sel_req` or new `sel_*` values during a burst are ignored. The captured copies are used.
- In IDLE and SEL_DONE, `ram_wren_a`=0 and address/data hold their last values.
- Reset (async assert) sets state IDLE and all outputs 0, and clears the rvalid pipeline.
  - A burst interrupted by reset is abandoned: no further writes, no `sel_done`.
  - Release is synchronised internally. The first arbitration happens on the second rising edge after deassertion.

## Timing
- CPU request seen in IDLE at edge N: `cpu_gnt` and the RAM drive are in cycle N+1. Read data arrives at cycle N+1+RD_LAT.
- CPU throughput: one access per 2 cycles.
- Selection request seen at edge N: byte writes in cycles N+1..N+4, `sel_done` in N+5, IDLE again at N+6.
- A CPU request waiting behind a burst is granted no earlier than N+7.
- `mode` changes during CPU_ACC, SEL_WR or SEL_DONE take effect at the next IDLE.

## Configuration
- `ARB_CPU_STALL_CNT_EN`
  - Defined: adds output `cpu_stall_cnt` [15:0]. It increments every cycle `cpu_req`=1 and `cpu_gnt`=0, saturates at 16'hFFFF, and resets to 0.
  - Undefined: the port and counter are absent. Arbitration behaviour is identical either way.

## Test plan
- Reset, then `sel_req` with `sel_addr`=19'h30E4D, `sel_word`=32'h0001_2C64.
  - Writes 8'h64@30E4D, 8'h2C@30E4E, 8'h01@30E4F, 8'h00@30E50 on consecutive cycles.
  - `sel_done` one cycle later.
- CPU write 8'hA5 to 19'h00010, then read the same address.
  - `cpu_gnt` is 1 cycle after each request.
  - `cpu_rvalid` with `cpu_rdata`=8'hA5 is RD_LAT cycles after the read grant.
- `sel_req` and `cpu_req` rise together.
  - With `mode`=0: 4 selection writes, `sel_done`, then `cpu_gnt` at +7.
  - With `mode`=1: `cpu_gnt` at +1, burst starts at +3.
- Burst with `sel_addr`=19'h7FFFE: byte addresses 7FFFE, 7FFFF, 00000, 00001.
- `reset_n` low during the second byte write: no third or fourth write, `sel_done` never pulses, outputs 0 while in reset. After release, a fresh burst completes normally.
- With `ARB_CPU_STALL_CNT_EN`: CPU held off by one burst reads `cpu_stall_cnt`=6.
